// File: rtl/immgen_pipe.sv
// immgen_pipe: per-lane RV32 immediate/format decoder feeding a 2-entry
// skid FIFO of decoded beats (raw instructions are never stored).
// Optional feature macro: IMMGEN_PIPE_FPU_EN adds FLOAD/FSTORE/OP-FP/FBRANCH.
module immgen_pipe #(
    parameter int unsigned LANES = 2,
    parameter int unsigned ILEN  = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*ILEN-1:0]   in_instr,
    input  logic [LANES-1:0]        in_lane_valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ILEN-1:0]   out_imm,
    output logic [LANES*3-1:0]      out_fmt,
    output logic [LANES-1:0]        out_illegal,
    output logic [LANES-1:0]        out_lane_valid
);

    localparam int unsigned FW    = 3;
    localparam int unsigned DW    = ILEN + FW + 1;
    localparam int unsigned DEPTH = 2;

    localparam logic [FW-1:0] FMT_NONE = 3'd0;
    localparam logic [FW-1:0] FMT_I    = 3'd1;
    localparam logic [FW-1:0] FMT_S    = 3'd2;
    localparam logic [FW-1:0] FMT_B    = 3'd3;
    localparam logic [FW-1:0] FMT_U    = 3'd4;
    localparam logic [FW-1:0] FMT_J    = 3'd5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
`ifdef IMMGEN_PIPE_FPU_EN
    localparam logic [6:0] OPC_FLOAD   = 7'b0000111;
    localparam logic [6:0] OPC_FSTORE  = 7'b0100111;
    localparam logic [6:0] OPC_OPFP    = 7'b1010011;
    localparam logic [6:0] OPC_FBRANCH = 7'b1100001;
`endif

    // Decode one instruction into {illegal, fmt, imm}.
    function automatic logic [DW-1:0] decode(input logic [ILEN-1:0] i);
        logic [ILEN-1:0] imm;
        logic [FW-1:0]   fmt;
        logic            ill;
        imm = '0;
        fmt = FMT_NONE;
        ill = 1'b0;
        case (i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = {i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
`ifdef IMMGEN_PIPE_FPU_EN
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_FLOAD: begin
`else
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
`endif
                fmt = FMT_I;
                imm = {{20{i[31]}}, i[31:20]};
            end
`ifdef IMMGEN_PIPE_FPU_EN
            OPC_STORE, OPC_FSTORE: begin
`else
            OPC_STORE: begin
`endif
                fmt = FMT_S;
                imm = {{20{i[31]}}, i[31:25], i[11:7]};
            end
`ifdef IMMGEN_PIPE_FPU_EN
            OPC_BRANCH, OPC_FBRANCH: begin
`else
            OPC_BRANCH: begin
`endif
                fmt = FMT_B;
                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            end
`ifdef IMMGEN_PIPE_FPU_EN
            OPC_OP, OPC_OPFP: begin
`else
            OPC_OP: begin
`endif
                fmt = FMT_NONE;
            end
            default: begin
                ill = 1'b1;
            end
        endcase
        return {ill, fmt, imm};
    endfunction

    logic [LANES*ILEN-1:0] dec_imm;
    logic [LANES*FW-1:0]   dec_fmt;
    logic [LANES-1:0]      dec_ill;
    logic [DW-1:0]         dec_word;

    logic [LANES*ILEN-1:0] imm_q   [DEPTH];
    logic [LANES*FW-1:0]   fmt_q   [DEPTH];
    logic [LANES-1:0]      ill_q   [DEPTH];
    logic [LANES-1:0]      lv_q    [DEPTH];

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       ready_q, ready_d;
    logic       valid_q, valid_d;
    logic       push, pop;

    // Input-side decode of every lane; empty lanes are forced to a null result.
    always_comb begin
        dec_imm  = '0;
        dec_fmt  = '0;
        dec_ill  = '0;
        dec_word = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            dec_word = decode(in_instr[l*ILEN +: ILEN]);
            if (in_lane_valid[l]) begin
                dec_imm[l*ILEN +: ILEN] = dec_word[ILEN-1:0];
                dec_fmt[l*FW +: FW]     = dec_word[ILEN +: FW];
                dec_ill[l]              = dec_word[DW-1];
            end
        end
    end

    assign push = in_valid && ready_q;
    assign pop  = valid_q && out_ready;

    // FIFO occupancy/pointer next state; flush wins over push and pop.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
        ready_d = (count_d != 2'd2);
        valid_d = (count_d != 2'd0);
    end

    // State registers and decoded-beat storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            for (int e = 0; e < int'(DEPTH); e++) begin
                imm_q[e] <= '0;
                fmt_q[e] <= '0;
                ill_q[e] <= '0;
                lv_q[e]  <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            if (push && !flush) begin
                imm_q[wr_ptr_q] <= dec_imm;
                fmt_q[wr_ptr_q] <= dec_fmt;
                ill_q[wr_ptr_q] <= dec_ill;
                lv_q[wr_ptr_q]  <= in_lane_valid;
            end
        end
    end

    assign in_ready       = ready_q;
    assign out_valid      = valid_q;
    assign out_imm        = imm_q[rd_ptr_q];
    assign out_fmt        = fmt_q[rd_ptr_q];
    assign out_illegal    = ill_q[rd_ptr_q];
    assign out_lane_valid = lv_q[rd_ptr_q];

endmodule

// File: tb/tb_immgen_pipe.sv
// tb_immgen_pipe: directed vectors for immgen_pipe (LANES=2) with hand-computed results.
module tb_immgen_pipe;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_instr;
    logic [1:0]  in_lane_valid;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [5:0]  out_fmt;
    logic [1:0]  out_illegal;
    logic [1:0]  out_lane_valid;

    int chk_cnt = 0;
    int err_cnt = 0;

    immgen_pipe #(.LANES(2), .ILEN(32)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_lane_valid  (in_lane_valid),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_imm        (out_imm),
        .out_fmt        (out_fmt),
        .out_illegal    (out_illegal),
        .out_lane_valid (out_lane_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [63:0] imm, input logic [5:0] fmt,
                            input logic [1:0] ill, input logic [1:0] lv);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
        chk({tag, "_imm"},   out_imm,        imm);
        chk({tag, "_fmt"},   64'(out_fmt),   64'(fmt));
        chk({tag, "_ill"},   64'(out_illegal), 64'(ill));
        chk({tag, "_lv"},    64'(out_lane_valid), 64'(lv));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] bp_instr(input int k);
        logic [31:0] l0;
        logic [31:0] l1;
        l0 = (32'(k) << 20) | 32'h0000_0013;
        l1 = (32'(k) << 12) | 32'h0000_0037;
        return {l1, l0};
    endfunction

    function automatic logic [63:0] bp_imm(input int k);
        return {32'(k) << 12, 32'(k)};
    endfunction

    initial begin
        rstn          = 1'b0;
        flush         = 1'b0;
        in_valid      = 1'b0;
        in_instr      = '0;
        in_lane_valid = 2'b11;
        out_ready     = 1'b0;
        #12;
        // reset state
        chk("rst_in_ready",  64'(in_ready),       64'(1'b1));
        chk("rst_out_valid", 64'(out_valid),      64'(1'b0));
        chk("rst_imm",       out_imm,             64'h0);
        chk("rst_fmt",       64'(out_fmt),        64'h0);
        chk("rst_ill",       64'(out_illegal),    64'h0);
        chk("rst_lv",        64'(out_lane_valid), 64'h0);
        rstn = 1'b1;
        step();

        // I + U lanes, first-beat latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = {32'h1234_50B7, 32'hFFF0_0093};
        step();
        chk_beat("iu", {32'h1234_5000, 32'hFFFF_FFFF}, {3'd4, 3'd1}, 2'b00, 2'b11);

        // B + J lanes, back-to-back throughput
        in_instr = {32'h0080_006F, 32'hFE00_0EE3};
        step();
        chk_beat("bj", {32'h0000_0008, 32'hFFFF_FFFC}, {3'd5, 3'd3}, 2'b00, 2'b11);

        // FLW on lane0, OP (no immediate) on lane1
        in_instr = {32'h0000_0033, 32'h0045_2007};
        step();
`ifdef IMMGEN_PIPE_FPU_EN
        chk_beat("flw", {32'h0, 32'h0000_0004}, {3'd0, 3'd1}, 2'b00, 2'b11);
`else
        chk_beat("flw", {32'h0, 32'h0}, {3'd0, 3'd0}, 2'b01, 2'b11);
`endif

        // STORE on lane0, unknown opcode on lane1
        in_instr = {32'hFFFF_FFFF, 32'h0011_2A23};
        step();
        chk_beat("sx", {32'h0, 32'h0000_0014}, {3'd0, 3'd2}, 2'b10, 2'b11);

        // drain
        in_valid = 1'b0;
        step();
        chk("drain_valid", 64'(out_valid), 64'(1'b0));

        // backpressure: three beats offered while the consumer stalls
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = bp_instr(1);
        chk("bp_rdy1", 64'(in_ready), 64'(1'b1));
        step();
        in_instr = bp_instr(2);
        chk("bp_rdy2", 64'(in_ready), 64'(1'b1));
        step();
        chk("bp_full", 64'(in_ready), 64'(1'b0));
        in_instr = bp_instr(3);
        step();
        chk("bp_stall", 64'(in_ready), 64'(1'b0));
        chk_beat("bp_hold", bp_imm(1), {3'd4, 3'd1}, 2'b00, 2'b11);
        out_ready = 1'b1;
        step();
        chk_beat("bp_b2", bp_imm(2), {3'd4, 3'd1}, 2'b00, 2'b11);
        chk("bp_rdy_back", 64'(in_ready), 64'(1'b1));
        step();
        chk_beat("bp_b3", bp_imm(3), {3'd4, 3'd1}, 2'b00, 2'b11);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 64'(out_valid), 64'(1'b0));

        // flush with count 2 and a same-cycle input beat
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = bp_instr(4);
        step();
        step();
        chk("fl_full", 64'(in_ready), 64'(1'b0));
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'(1'b0));
        chk("fl_ready", 64'(in_ready),  64'(1'b1));
        step();
        chk("fl_stays_empty", 64'(out_valid), 64'(1'b0));

        // asynchronous reset with one beat buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = bp_instr(5);
        step();
        in_valid = 1'b0;
        chk("ar_pre", 64'(out_valid), 64'(1'b1));
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'(1'b0));
        chk("ar_ready", 64'(in_ready),  64'(1'b1));
        chk("ar_imm",   out_imm,        64'h0);
        #2;
        rstn = 1'b1;

        // partial lane occupancy, accepted on the first edge after reset
        in_valid      = 1'b1;
        in_lane_valid = 2'b01;
        in_instr      = {32'hFFFF_FFFF, 32'hFFF0_0093};
        step();
        in_valid = 1'b0;
        chk_beat("lv01", {32'h0, 32'hFFFF_FFFF}, {3'd0, 3'd1}, 2'b00, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
